// File: rtl/mem_debug_dumper.sv
// Walks data memory words 0..TAM-1 over the debug port and streams each word LSB-first to the UART TX.
// Optional MEM_DUMP_HEADER_EN prepends the two-byte header 0xA5, TAM[7:0] to every dump.
module mem_debug_dumper #(
    parameter int          NBITS = 32,
    parameter int unsigned TAM   = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    output logic [NBITS-1:0] o_debug_address,
    input  logic [NBITS-1:0] i_debug_data,
    output logic [7:0]       o_tx_data,
    output logic             o_tx_start,
    input  logic             i_tx_done,
    output logic             o_busy,
    output logic             o_done
);

    localparam int NBYTES = NBITS / 8;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NBYTES - 1);
    localparam logic [NBITS-1:0] LAST_ADDR = NBITS'(TAM - 1);
`ifdef MEM_DUMP_HEADER_EN
    localparam logic [7:0] HDR_MAGIC = 8'hA5;
    localparam logic [7:0] HDR_TAM   = 8'(TAM);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_LATCH,
        S_SEND,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [NBITS-1:0] addr_q, addr_d;
    logic [NBITS-1:0] shift_q, shift_d;
    logic [NBITS-1:0] shift_next;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_start_q, tx_start_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef MEM_DUMP_HEADER_EN
    // 2: magic byte in flight, 1: TAM byte in flight, 0: data phase
    logic [1:0]       hdr_q, hdr_d;
`endif

    assign shift_next = shift_q >> 8;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
`ifdef MEM_DUMP_HEADER_EN
        hdr_d      = hdr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    addr_d = '0;
                    busy_d = 1'b1;
`ifdef MEM_DUMP_HEADER_EN
                    hdr_d     = 2'd2;
                    tx_data_d = HDR_MAGIC;
                    state_d   = S_SEND;
`else
                    state_d   = S_SETTLE;
`endif
                end
            end
            // Address has been stable since entry; the memory read path resolves here.
            S_SETTLE: state_d = S_LATCH;
            S_LATCH: begin
                shift_d   = i_debug_data;
                idx_d     = '0;
                tx_data_d = i_debug_data[7:0];
                state_d   = S_SEND;
            end
            S_SEND: begin
                tx_start_d = 1'b1;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (i_tx_done) begin
`ifdef MEM_DUMP_HEADER_EN
                    if (hdr_q == 2'd2) begin
                        hdr_d     = 2'd1;
                        tx_data_d = HDR_TAM;
                        state_d   = S_SEND;
                    end else if (hdr_q == 2'd1) begin
                        hdr_d   = 2'd0;
                        state_d = S_SETTLE;
                    end else
`endif
                    begin
                        if (idx_q != LAST_IDX) begin
                            shift_d   = shift_next;
                            idx_d     = idx_q + IDX_W'(1);
                            tx_data_d = shift_next[7:0];
                            state_d   = S_SEND;
                        end else if (addr_q == LAST_ADDR) begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            addr_d  = addr_q + NBITS'(1);
                            state_d = S_SETTLE;
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            shift_q    <= '0;
            idx_q      <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef MEM_DUMP_HEADER_EN
            hdr_q      <= 2'd0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef MEM_DUMP_HEADER_EN
            hdr_q      <= hdr_d;
`endif
        end
    end

    assign o_debug_address = addr_q;
    assign o_tx_data       = tx_data_q;
    assign o_tx_start      = tx_start_q;
    assign o_busy          = busy_q;
    assign o_done          = done_q;

endmodule

// File: tb/tb_mem_debug_dumper.sv
// Directed bench: memory model plus UART responder, checking byte stream, addresses, latency and control pulses.
module tb_mem_debug_dumper;

    localparam int NBITS = 32;
    localparam int TAM   = 16;
    localparam int DLY   = 5;
`ifdef MEM_DUMP_HEADER_EN
    localparam int HDR = 2;
    localparam int LAT = 2;
`else
    localparam int HDR = 0;
    localparam int LAT = 4;
`endif
    localparam int TOTAL = HDR + TAM * 4;

    logic             i_clk = 1'b0;
    logic             i_reset = 1'b1;
    logic             i_start = 1'b0;
    logic [NBITS-1:0] o_debug_address;
    logic [NBITS-1:0] i_debug_data;
    logic [7:0]       o_tx_data;
    logic             o_tx_start;
    logic             i_tx_done = 1'b0;
    logic             o_busy;
    logic             o_done;

    int n_cmp = 0;
    int n_bad = 0;
    int pat = 0;
    int done_high = 0;
    int stall_at = -1;
    int done_cnt = 0;
    int cnt = 0;
    logic [7:0]  bytes_q[$];
    logic [31:0] addrs_q[$];

    mem_debug_dumper #(.NBITS(NBITS), .TAM(TAM)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
        .o_debug_address(o_debug_address), .i_debug_data(i_debug_data),
        .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    // Memory: pattern 0 is word i = i; pattern 1 has a distinct value in every byte lane.
    always_comb begin
        logic [7:0] a;
        a = o_debug_address[7:0];
        if (o_debug_address >= TAM)
            i_debug_data = 32'hDEADBEEF;
        else if (pat == 0)
            i_debug_data = o_debug_address;
        else
            i_debug_data = {8'hA0 + a, 8'hB0 + a, 8'hC0 + a, 8'hD0 + a};
    end

    // UART TX model: logs each strobe and answers with i_tx_done DLY cycles later.
    initial begin
        forever begin
            @(negedge i_clk);
            if (i_reset) begin
                cnt = 0;
                i_tx_done = 1'b0;
            end else begin
                if (done_high != 0) begin
                    i_tx_done = 1'b1;
                end else begin
                    i_tx_done = 1'b0;
                    if (cnt > 0) begin
                        cnt--;
                        if (cnt == 0) i_tx_done = 1'b1;
                    end
                end
                if (o_tx_start) begin
                    bytes_q.push_back(o_tx_data);
                    addrs_q.push_back(o_debug_address);
                    cnt = (bytes_q.size() == stall_at) ? DLY + 100 : DLY;
                end
                if (o_done) done_cnt++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int k);
        int j, w, b;
        if (k < HDR) return (k == 0) ? 8'hA5 : 8'(TAM);
        j = k - HDR;
        w = j / 4;
        b = j % 4;
        if (pat == 0) return (b == 0) ? 8'(w) : 8'h00;
        case (b)
            0: return 8'hD0 + 8'(w);
            1: return 8'hC0 + 8'(w);
            2: return 8'hB0 + 8'(w);
            default: return 8'hA0 + 8'(w);
        endcase
    endfunction

    function automatic logic [31:0] exp_addr(input int k);
        return (k < HDR) ? 32'd0 : 32'((k - HDR) / 4);
    endfunction

    task automatic start_dump(input string tag);
        int n;
        bytes_q.delete();
        addrs_q.delete();
        done_cnt = 0;
        @(negedge i_clk);
        i_start = 1'b1;
        for (n = 1; n <= 20; n++) begin
            @(negedge i_clk);
            if (n == 1) i_start = 1'b0;
            if (o_tx_start) break;
        end
        check({tag, "_latency"}, n, LAT);
    endtask

    task automatic wait_bytes(input string tag, input int nb);
        int t;
        for (t = 0; t < 5000 && bytes_q.size() < nb; t++) @(negedge i_clk);
        if (bytes_q.size() < nb) check({tag, "_wait_bytes_timeout"}, bytes_q.size(), nb);
    endtask

    task automatic wait_done(input string tag);
        int t;
        for (t = 0; t < 5000 && done_cnt == 0; t++) @(negedge i_clk);
        if (done_cnt == 0) check({tag, "_wait_done_timeout"}, 0, 1);
        repeat (40) @(negedge i_clk);
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_count"}, bytes_q.size(), TOTAL);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_busy_after"}, o_busy, 1'b0);
        check({tag, "_addr_hold"}, o_debug_address, TAM - 1);
        for (int k = 0; k < TOTAL && k < bytes_q.size(); k++) begin
            check($sformatf("%s_byte%0d", tag, k), bytes_q[k], exp_byte(k));
            check($sformatf("%s_addr%0d", tag, k), addrs_q[k], exp_addr(k));
        end
    endtask

    initial begin
        int bad_hold;
        // Reset state
        repeat (3) @(negedge i_clk);
        check("rst_tx_start", o_tx_start, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_done", o_done, 1'b0);
        check("rst_tx_data", o_tx_data, 8'h00);
        check("rst_addr", o_debug_address, 32'd0);
        i_reset = 1'b0;
        repeat (10) @(negedge i_clk);
        check("idle_no_strobe", bytes_q.size(), 0);

        // Plain dump, pattern 0, done after DLY cycles
        pat = 0;
        start_dump("d0");
        wait_done("d0");
        check_stream("d0");

        // Pattern 1 with i_tx_done held high throughout
        pat = 1;
        done_high = 1;
        start_dump("dh");
        wait_done("dh");
        check_stream("dh");
        done_high = 0;

        // Second i_start mid-dump is ignored
        pat = 0;
        start_dump("rs");
        wait_bytes("rs", HDR + 20);
        check("rs_busy_mid", o_busy, 1'b1);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        wait_done("rs");
        repeat (60) @(negedge i_clk);
        check_stream("rs");

        // Stall i_tx_done for 100 cycles on the byte carrying 0x01
        stall_at = HDR + 5;
        start_dump("st");
        wait_bytes("st", HDR + 5);
        bad_hold = 0;
        repeat (100) begin
            @(negedge i_clk);
            if (o_tx_start || o_tx_data !== 8'h01 || bytes_q.size() != HDR + 5 || o_busy !== 1'b1)
                bad_hold++;
        end
        check("st_hold_stable", bad_hold, 0);
        wait_done("st");
        stall_at = -1;
        check_stream("st");

        // Asynchronous reset mid-dump, then a fresh dump
        start_dump("ab");
        wait_bytes("ab", HDR + 10);
        #3 i_reset = 1'b1;
        #1;
        check("ab_rst_busy", o_busy, 1'b0);
        check("ab_rst_tx_start", o_tx_start, 1'b0);
        check("ab_rst_tx_data", o_tx_data, 8'h00);
        check("ab_rst_addr", o_debug_address, 32'd0);
        @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
        repeat (30) @(negedge i_clk);
        check("ab_no_done", done_cnt, 0);
        check("ab_idle", o_busy, 1'b0);
        start_dump("nw");
        wait_done("nw");
        check_stream("nw");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
